// File: rtl/logic_unit_iter.sv
// Iterative bitwise logic unit: eight two-operand functions evaluated SLICE bits per cycle.
// Optional parity output enabled by defining LOGIC_UNIT_PARITY_EN.
module logic_unit_iter #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero
`ifdef LOGIC_UNIT_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = $clog2(NSLICE) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NSLICE - 1);

  generate
    if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("logic_unit_iter: WIDTH must be >= 1 and a multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, y_q;
  logic [2:0]         op_q;
  logic [CNT_W-1:0]   idx_q;
  logic               zero_q;
  logic               accept;
  logic [SLICE-1:0]   slice_res;

  function automatic logic [SLICE-1:0] logic_fn(input logic [2:0] f,
                                                input logic [SLICE-1:0] x,
                                                input logic [SLICE-1:0] z);
    case (f)
      3'b000:  return x | z;
      3'b001:  return x & z;
      3'b010:  return x ^ z;
      3'b011:  return ~(x | z);
      3'b100:  return ~(x & z);
      3'b101:  return ~(x ^ z);
      3'b110:  return x & ~z;
      default: return x | ~z;
    endcase
  endfunction

  assign accept    = in_valid && (state_q == IDLE);
  assign slice_res = logic_fn(op_q, a_q[idx_q*SLICE +: SLICE], b_q[idx_q*SLICE +: SLICE]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // Operands are pure data: captured at accept, never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      zero_q <= 1'b1;
      idx_q  <= '0;
    end else if (accept) begin
      y_q    <= '0;
      zero_q <= 1'b1;
      idx_q  <= '0;
    end else if (state_q == RUN) begin
      y_q[idx_q*SLICE +: SLICE] <= slice_res;
      zero_q <= zero_q & ~(|slice_res);
      idx_q  <= idx_q + 1'b1;
    end
  end

`ifdef LOGIC_UNIT_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 parity_q <= 1'b0;
    else if (accept)            parity_q <= 1'b0;
    else if (state_q == RUN)    parity_q <= parity_q ^ (^slice_res);
  end

  assign parity = parity_q;
`endif

  assign y    = y_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_logic_unit_iter.sv
// Randomized self-checking bench for logic_unit_iter against a whole-word reference model.
module tb_logic_unit_iter;

  parameter int WIDTH = 64;
  parameter int SLICE = 16;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a, b, y;
  logic             zero;
`ifdef LOGIC_UNIT_PARITY_EN
  logic             parity;
`endif

  int checks   = 0;
  int failures = 0;

  logic_unit_iter #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero)
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    .parity    (parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [2:0] f,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] z);
    logic [WIDTH-1:0] r;
    case (f)
      3'd0:    r = x | z;
      3'd1:    r = x & z;
      3'd2:    r = x ^ z;
      3'd3:    r = ~(x | z);
      3'd4:    r = ~(x & z);
      3'd5:    r = ~(x ^ z);
      3'd6:    r = x & ~z;
      default: r = x | ~z;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_word();
    logic [WIDTH+31:0] t;
    t = '0;
    for (int i = 0; i < (WIDTH + 31) / 32; i++) t = {t[WIDTH-1:0], 32'($urandom)};
    return t[WIDTH-1:0];
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  256'(in_ready),  256'(1));
    check({tag, "_out_valid"}, 256'(out_valid), 256'(0));
    check({tag, "_y"},         256'(y),         256'(0));
    check({tag, "_zero"},      256'(zero),      256'(1));
`ifdef LOGIC_UNIT_PARITY_EN
    check({tag, "_parity"},    256'(parity),    256'(0));
`endif
  endtask

  // One operation; caller is positioned 1 time unit after a rising edge.
  task automatic do_op(input logic [2:0] op_i, input logic [WIDTH-1:0] a_i,
                       input logic [WIDTH-1:0] b_i, input int hold);
    logic [WIDTH-1:0] ey;
    logic [WIDTH-1:0] y_seen;
    int cyc;
    ey = model(op_i, a_i, b_i);
    cyc = 0;
    while (!in_ready && cyc < 4 * NSLICE + 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("in_ready_wait", 256'(in_ready), 256'(1));
    op = op_i; a = a_i; b = b_i; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom_range(0, 7)); a = rnd_word(); b = rnd_word();
    check("busy_in_ready", 256'(in_ready), 256'(0));
    cyc = 0;
    while (!out_valid && cyc < NSLICE + 10) begin
      @(posedge clk); #1; cyc++;
    end
    check("latency", 256'(cyc + 1), 256'(NSLICE + 1));
    check("y", 256'(y), 256'(ey));
    check("zero", 256'(zero), 256'(ey == '0));
`ifdef LOGIC_UNIT_PARITY_EN
    check("parity", 256'(parity), 256'(^ey));
`endif
    y_seen = y;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("hold_y", 256'(y), 256'(y_seen));
      check("hold_out_valid", 256'(out_valid), 256'(1));
      check("hold_in_ready", 256'(in_ready), 256'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handoff_out_valid", 256'(out_valid), 256'(0));
    check("handoff_in_ready", 256'(in_ready), 256'(1));
  endtask

  initial begin
    int acc[$];
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("reset");

    // Abort mid-RUN with an asynchronous reset.
    op = 3'd0; a = '1; b = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_idle("abort");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(3'b000, WIDTH'(64'hF0F0_0000_0000_000F), WIDTH'(64'h0F0F_0000_0000_00F0), 0);
    do_op(3'b010, WIDTH'(64'h1234_5678_9ABC_DEF0), WIDTH'(64'h1234_5678_9ABC_DEF0), 0);
    for (int k = 0; k < 8; k++)
      do_op(3'(k), WIDTH'(64'hFFFF_FFFF_0000_0000), WIDTH'(64'hFFFF_0000_FFFF_0000), 0);
    do_op(3'b100, '1, '1, 10);
    for (int k = 0; k < 25; k++)
      do_op(3'($urandom_range(0, 7)), rnd_word(), rnd_word(), int'($urandom_range(0, 3)));

    // Back-to-back throughput with in_valid and out_ready held high.
    @(negedge clk);
    op = 3'b001; a = rnd_word(); b = rnd_word(); in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 5 * (NSLICE + 2) + 10 && acc.size() < 3; c++) begin
      if (in_ready) acc.push_back(c);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("tput_accepts", 256'(acc.size()), 256'(3));
    if (acc.size() == 3) begin
      check("tput_gap0", 256'(acc[1] - acc[0]), 256'(NSLICE + 2));
      check("tput_gap1", 256'(acc[2] - acc[1]), 256'(NSLICE + 2));
    end
    repeat (NSLICE + 4) @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("final_in_ready", 256'(in_ready), 256'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
